// File: rtl/dsc_mul_seq.sv
// Operand sequencer for dsc_mul: accepts one operand pair, drives the multiplier
// through a clear/run cycle, waits for ov (or a timeout), and presents the product,
// the RUN cycle count and an error flag on a valid/ready result stream.
module dsc_mul_seq #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 20,
    parameter int TIMEOUT   = 131072
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_z,
    output logic [CNT_WIDTH-1:0]   out_cycles,
    output logic                   out_err,
    output logic                   mul_rst,
    output logic                   mul_en,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [2*WIDTH-1:0]     mul_z,
    input  logic                   mul_ov
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    state_t                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]     out_z_q, out_z_d;
    logic [CNT_WIDTH-1:0]   out_cycles_q, out_cycles_d;
    logic                   out_err_q, out_err_d;
    logic                   mul_rst_q, mul_rst_d;
    logic                   mul_en_q, mul_en_d;
    logic [WIDTH-1:0]       mul_a_q, mul_a_d;
    logic [WIDTH-1:0]       mul_b_q, mul_b_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Next-state and next-output logic; every output is the registered copy of a _d value.
    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_z_d      = out_z_q;
        out_cycles_d = out_cycles_q;
        out_err_d    = out_err_q;
        mul_rst_d    = mul_rst_q;
        mul_en_d     = mul_en_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mul_a_d    = in_a;
                    mul_b_d    = in_b;
                    in_ready_d = 1'b0;
                    if ((in_a == '0) || (in_b == '0)) begin
                        // A zero operand has a known product; skip the multiplier.
                        state_d      = DONE;
                        out_valid_d  = 1'b1;
                        out_z_d      = '0;
                        out_cycles_d = '0;
                        out_err_d    = 1'b0;
                    end else begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end
                end
            end
            CLEAR: begin
                // mul_rst has been high for this one cycle; release it and start running.
                state_d   = RUN;
                mul_rst_d = 1'b0;
                mul_en_d  = 1'b1;
                cnt_d     = '0;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (mul_ov) begin
                    // ov takes priority even on the very cycle the timeout would fire.
                    state_d      = DONE;
                    out_valid_d  = 1'b1;
                    out_z_d      = mul_z;
                    out_cycles_d = cnt_inc;
                    out_err_d    = 1'b0;
                    mul_rst_d    = 1'b1;
                    mul_en_d     = 1'b0;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d      = DONE;
                    out_valid_d  = 1'b1;
                    out_z_d      = '0;
                    out_cycles_d = TIMEOUT_C;
                    out_err_d    = 1'b1;
                    mul_rst_d    = 1'b1;
                    mul_en_d     = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_z_q      <= '0;
            out_cycles_q <= '0;
            out_err_q    <= 1'b0;
            mul_rst_q    <= 1'b1;
            mul_en_q     <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_z_q      <= out_z_d;
            out_cycles_q <= out_cycles_d;
            out_err_q    <= out_err_d;
            mul_rst_q    <= mul_rst_d;
            mul_en_q     <= mul_en_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_z      = out_z_q;
    assign out_cycles = out_cycles_q;
    assign out_err    = out_err_q;
    assign mul_rst    = mul_rst_q;
    assign mul_en     = mul_en_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq with a behavioural dsc_mul stand-in:
// ov is raised during the K-th enabled cycle after reset release, z = a*b.
module tb_dsc_mul_seq;

    localparam int W  = 8;
    localparam int CW = 20;
    localparam int TO = 4096;   // shortened timeout keeps the run short

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_a = '0;
    logic [W-1:0]    in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  out_z;
    logic [CW-1:0]   out_cycles;
    logic            out_err;
    logic            mul_rst;
    logic            mul_en;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic [2*W-1:0]  mul_z;
    logic            mul_ov;

    int tests = 0;
    int fails = 0;

    // Multiplier model configuration, written only by the stimulus block.
    int k_cfg = 1;
    bit never_cfg = 1'b0;
    int m_cnt = 0;
    int en_cycles = 0;
    int hs_count = 0;

    always #5 clk = ~clk;

    dsc_mul_seq #(.WIDTH(W), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .out_cycles(out_cycles), .out_err(out_err),
        .mul_rst(mul_rst), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_z(mul_z), .mul_ov(mul_ov)
    );

    // Behavioural dsc_mul: counts enabled cycles since its reset.
    always @(posedge clk) begin
        if (mul_rst) m_cnt <= 0;
        else if (mul_en) m_cnt <= m_cnt + 1;
    end
    assign mul_ov = mul_en && !mul_rst && !never_cfg && (m_cnt == k_cfg - 1);
    assign mul_z  = mul_a * mul_b;

    // Activity monitor: enable cycles and completed result handshakes.
    always @(posedge clk) begin
        if (mul_en) en_cycles <= en_cycles + 1;
        if (out_valid && out_ready) hs_count <= hs_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a pair and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        int n;
        n = 0;
        k_cfg = k;
        while (!in_ready && n < 100) begin tick(); n++; end
        chk("send_ready", in_ready, 1);
        in_a = a; in_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("accept_ready_low", in_ready, 0);
    endtask

    // Wait for a result, compare it, optionally stall, then complete the handshake.
    task automatic take(input logic [2*W-1:0] ez, input int ec, input bit ee, input int stall);
        int n;
        n = 0;
        out_ready = (stall == 0);
        while (!out_valid && n < TO + 50) begin tick(); n++; end
        chk("out_valid_seen", out_valid, 1);
        chk("out_z", out_z, ez);
        chk("out_cycles", out_cycles, ec);
        chk("out_err", out_err, ee);
        $display("[TB] txn a=%0d b=%0d z=%0d cycles=%0d err=%0b", mul_a, mul_b, out_z, out_cycles, out_err);
        if (stall > 0) begin
            repeat (stall) tick();
            chk("stall_valid", out_valid, 1);
            out_ready = 1'b1;
        end
        tick();
        chk("valid_drop", out_valid, 0);
        chk("ready_back", in_ready, 1);
    endtask

    initial begin
        logic [2*W-1:0] z_hold;
        int n, hs0, en0;

        // Reset values
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_out_cycles", out_cycles, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_mul_rst", mul_rst, 1);
        chk("rst_mul_en", mul_en, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        rst_n = 1'b1;
        tick();

        // 1. 15*15 with K=225; exactly one CLEAR cycle before enable
        k_cfg = 225;
        out_ready = 1'b1;
        in_a = 15; in_b = 15; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_clear", {mul_rst, mul_en, in_ready}, 3'b100);
        chk("t1_mul_a", mul_a, 15);
        tick();
        chk("t1_run", {mul_rst, mul_en}, 2'b01);
        n = 0;
        while (!out_valid && n < 400) begin tick(); n++; end
        chk("t1_latency", n, 225);
        chk("t1_done_mul", {mul_rst, mul_en, in_ready}, 3'b100);
        take(16'd225, 225, 1'b0, 0);

        // 2. Zero operand bypasses the multiplier
        en0 = en_cycles;
        in_a = 0; in_b = 200; in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t2_valid_next", out_valid, 1);
        take(16'd0, 0, 1'b0, 0);
        chk("t2_no_enable", en_cycles, en0);

        // 3. Timeout with ov never raised
        never_cfg = 1'b1;
        send(255, 255, 1);
        take(16'd0, TO, 1'b1, 0);
        never_cfg = 1'b0;

        // ov on the same cycle as the timeout: ov wins
        send(3, 5, TO);
        take(16'd15, TO, 1'b0, 0);
        // shortest run
        send(2, 3, 1);
        take(16'd6, 1, 1'b0, 0);

        // 4. Held result with out_ready low for 50 cycles, second pair waiting
        send(6, 7, 5);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        z_hold = out_z;
        chk("t4_z", z_hold, 42);
        in_a = 9; in_b = 9; in_valid = 1'b1;
        k_cfg = 4;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("t4_hold", {out_valid, in_ready, out_z, out_cycles, out_err, mul_a},
                {1'b1, 1'b0, 16'd42, 20'd5, 1'b0, 8'd6});
        end
        out_ready = 1'b1;
        tick();
        chk("t4_hs", {out_valid, in_ready, mul_a}, {1'b0, 1'b1, 8'd6});
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t4_second_accept", {in_ready, mul_a, mul_b}, {1'b0, 8'd9, 8'd9});
        take(16'd81, 4, 1'b0, 0);

        // 5. Reset in the middle of RUN, then a fresh pair
        send(100, 3, 300);
        repeat (10) tick();
        chk("t5_running", mul_en, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_after_rst", {in_ready, out_valid, mul_rst, mul_en}, 4'b1010);
        hs0 = hs_count;
        send(7, 9, 10);
        take(16'd63, 10, 1'b0, 0);
        chk("t5_one_result", hs_count - hs0, 1);

        // 6. Random pairs against the model
        hs0 = hs_count;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            int k;
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            k = $urandom_range(1, 16);
            send(a, b, k);
            take(a * b, (a == 0 || b == 0) ? 0 : k, 1'b0, $urandom_range(0, 2));
        end
        chk("t6_result_count", hs_count - hs0, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
